fft_in_loader: RTL

Input loading stage of the FFT datapath. It accepts one complex 16-bit sample per handshake and produces a registered write strobe, packed data word and bank/address for the four-bank sample RAM. Its outputs feed the RAM enable/write controller, the RAM data-input mux (the 32-bit packed word is sign-extended downstream) and the RAM address mux during the load phase. It reports frame completion so the FFT sequencer can leave the load state.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_idx_map.sv | 26 ++
 rtl/fft_in_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, the loader state enumeration and the bank/address record.
package fft_pkg;

  localparam int N_SAMPLES = 1024;
  localparam int N_BANK    = 4;
  localparam int ADDR_W    = 8;
  localparam int IDX_W     = $clog2(N_SAMPLES);
  localparam int SEL_W     = $clog2(N_BANK);

  // Chip-select code the address/data muxes use while the loader owns the RAM.
  localparam logic [2:0] CS_LOAD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] cnt;
  } bank_addr_t;

endpackage

// File: rtl/fft_idx_map.sv
// Sample index -> {bank, address}. FFT_IN_BITREV_EN selects bit-reversed order
// for a decimation-in-time schedule; otherwise banks fill contiguously.
module fft_idx_map
  import fft_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [SEL_W-1:0]  o_sel,
  output logic [ADDR_W-1:0] o_cnt
);

  logic [IDX_W-1:0] w_map;
  bank_addr_t       w_ba;

`ifdef FFT_IN_BITREV_EN
  for (genvar b = 0; b < IDX_W; b++) begin : g_rev
    assign w_map[b] = i_idx[IDX_W-1-b];
  end
`else
  assign w_map = i_idx;
`endif

  assign w_ba  = bank_addr_t'(w_map);
  assign o_sel = w_ba.sel;
  assign o_cnt = w_ba.cnt;

endmodule

// File: rtl/fft_in_loader.sv
// FFT input loader: one complex sample per handshake into the four-bank RAM.
// Index mapping (natural or bit-reversed via FFT_IN_BITREV_EN) lives in fft_idx_map.
module fft_in_loader #(
  parameter int N_BANK = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         din_re,
  input  logic [DATA_W-1:0]         din_im,
  output logic [2*DATA_W-1:0]       buffer,
  output logic [ADDR_W-1:0]         cnt,
  output logic [$clog2(N_BANK)-1:0] sel,
  output logic                      ctrl,
  output logic                      load_busy,
  output logic                      frame_done,
  output logic                      ovf
);
  import fft_pkg::*;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_SAMPLES - 1);

  ld_state_t                  r_state;
  logic [IDX_W-1:0]           r_k;
  logic [2*DATA_W-1:0]        r_buf;
  logic [ADDR_W-1:0]          r_cnt;
  logic [$clog2(N_BANK)-1:0]  r_sel;
  logic                       r_ctrl;
  logic                       r_ovf;

  logic [SEL_W-1:0]           w_sel;
  logic [ADDR_W-1:0]          w_cnt;

  fft_idx_map u_map (
    .i_idx (r_k),
    .o_sel (w_sel),
    .o_cnt (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_ctrl  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ctrl <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_k     <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_ctrl <= 1'b1;
            r_buf  <= {din_re, din_im};
            r_sel  <= w_sel;
            r_cnt  <= w_cnt;
            // k parks at the last index; only the next start rewinds it.
            if (r_k == K_LAST) r_state <= ST_FLUSH;
            else               r_k     <= r_k + 1'b1;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          if (in_valid) r_ovf <= 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  assign in_ready   = (r_state == ST_LOAD);
  assign load_busy  = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
  assign frame_done = (r_state == ST_DONE);
  assign buffer     = r_buf;
  assign cnt        = r_cnt;
  assign sel        = r_sel;
  assign ctrl       = r_ctrl;
  assign ovf        = r_ovf;

endmodule
